vga_bw_line_feeder: RTL and testbench



---
 rtl/vga_bw_pkg.sv | 30 +++
 rtl/vga_bw_line_bank.sv | 26 ++
 rtl/vga_bw_line_feeder.sv | 150 +++++++++++++++
 tb/tb_vga_bw_line_feeder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_bw_pkg.sv
// Shared timing constants and bank-state encoding for the 1-bpp VGA line feeder.
// Latency: n/a (package only).
// Backpressure: n/a.
package vga_bw_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = 800;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = 525;

    localparam int WORD_W = 16;
    localparam int WPL    = H_DISPLAY / WORD_W;
    localparam int WI_W   = $clog2(WPL);
    localparam int PIX_W  = $clog2(WORD_W);
    localparam int CNT_W  = 10;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_st_t;

endpackage

// File: rtl/vga_bw_line_bank.sv
// One line of packed pixels: WPL x WORD_W register array, one write port, one read port.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none; the caller gates the write enable.
module vga_bw_line_bank
    import vga_bw_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [WI_W-1:0]   i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [WI_W-1:0]   i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [WPL];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Addresses past the line end come from blanking counts; return zeros there.
    assign o_rdata = (i_raddr < WI_W'(WPL)) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/vga_bw_line_feeder.sv
// Ping-pong 640-bit line buffer feeding 1-bpp pixels to the VGA stage; optional VGA_BW_UNDERRUN_PATTERN_EN shows a checkerboard on underrun lines.
// Latency: pixel registered 1 clock after its h_count/v_count.
// Backpressure: s_ready low while the write bank is FULL; freed when the displayed line releases it.
module vga_bw_line_feeder
    import vga_bw_pkg::*;
(
    input  logic              clk_25mhz,
    input  logic              reset,
    input  logic [CNT_W-1:0]  h_count,
    input  logic [CNT_W-1:0]  v_count,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_sof,
    output logic              pixel,
    output logic              underrun,
    input  logic              clr_underrun
);

    localparam logic [PIX_W-1:0] BIT_MAX = PIX_W'(WORD_W - 1);

    bank_st_t         r_bst [2];
    logic [WI_W-1:0]  r_wi;
    logic             r_wb;
    logic             r_rb;
    logic             r_act;
    logic             r_underrun;
    logic             r_pixel;

    bank_st_t         w_bst_nxt [2];
    logic [WI_W-1:0]  w_wi_nxt;
    logic             w_wb_nxt;
    logic             w_rb_nxt;
    logic             w_act_nxt;
    logic             w_ur_nxt;

    logic             w_wr;
    logic [WI_W-1:0]  w_widx;
    logic             w_vis;
    logic             w_take;
    logic             w_rel;
    logic [WI_W-1:0]  w_raddr;
    logic [PIX_W-1:0] w_bitsel;
    logic [WORD_W-1:0] w_rd0;
    logic [WORD_W-1:0] w_rd1;
    logic [WORD_W-1:0] w_rword;
    logic             w_pix_bit;
    logic             w_fill;

    assign s_ready  = (r_bst[r_wb] != BANK_FULL);
    assign w_wr     = s_valid && s_ready;
    // A start-of-line word always lands at index 0, dropping any partial line.
    assign w_widx   = s_sof ? '0 : r_wi;

    assign w_vis  = (h_count < CNT_W'(H_DISPLAY)) && (v_count < CNT_W'(V_DISPLAY));
    assign w_take = (h_count == CNT_W'(H_TOTAL - 1)) &&
                    ((v_count == CNT_W'(V_TOTAL - 1)) || (v_count < CNT_W'(V_DISPLAY - 1)));
    assign w_rel  = (h_count == CNT_W'(H_DISPLAY - 1)) && w_vis && r_act;

    assign w_raddr  = h_count[PIX_W+WI_W-1:PIX_W];
    assign w_bitsel = h_count[PIX_W-1:0];
    assign w_rword  = r_rb ? w_rd1 : w_rd0;
    assign w_pix_bit = w_rword[BIT_MAX - w_bitsel];

`ifdef VGA_BW_UNDERRUN_PATTERN_EN
    assign w_fill = h_count[5] ^ v_count[5];
`else
    assign w_fill = 1'b0;
`endif

    vga_bw_line_bank u_bank0 (
        .i_clk   (clk_25mhz),
        .i_we    (w_wr && !r_wb),
        .i_waddr (w_widx),
        .i_wdata (s_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rd0)
    );

    vga_bw_line_bank u_bank1 (
        .i_clk   (clk_25mhz),
        .i_we    (w_wr && r_wb),
        .i_waddr (w_widx),
        .i_wdata (s_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rd1)
    );

    // Write and release never touch the same bank: a FULL write bank blocks writes.
    always_comb begin
        w_bst_nxt = r_bst;
        w_wi_nxt  = r_wi;
        w_wb_nxt  = r_wb;
        w_rb_nxt  = r_rb;
        w_act_nxt = r_act;
        w_ur_nxt  = r_underrun && !clr_underrun;

        if (w_wr) begin
            if (w_widx == WI_W'(WPL - 1)) begin
                w_bst_nxt[r_wb] = BANK_FULL;
                w_wi_nxt        = '0;
                w_wb_nxt        = !r_wb;
            end else begin
                w_bst_nxt[r_wb] = BANK_FILLING;
                w_wi_nxt        = w_widx + 1'b1;
            end
        end

        // Take looks at pre-edge state, so a bank completing this cycle is missed.
        if (w_take) begin
            if (r_bst[r_rb] == BANK_FULL) begin
                w_act_nxt = 1'b1;
            end else begin
                w_act_nxt = 1'b0;
                w_ur_nxt  = 1'b1;
            end
        end

        if (w_rel) begin
            w_bst_nxt[r_rb] = BANK_EMPTY;
            w_rb_nxt        = !r_rb;
            w_act_nxt       = 1'b0;
        end
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            r_bst[0]   <= BANK_EMPTY;
            r_bst[1]   <= BANK_EMPTY;
            r_wi       <= '0;
            r_wb       <= 1'b0;
            r_rb       <= 1'b0;
            r_act      <= 1'b0;
            r_underrun <= 1'b0;
            r_pixel    <= 1'b0;
        end else begin
            r_bst      <= w_bst_nxt;
            r_wi       <= w_wi_nxt;
            r_wb       <= w_wb_nxt;
            r_rb       <= w_rb_nxt;
            r_act      <= w_act_nxt;
            r_underrun <= w_ur_nxt;
            r_pixel    <= w_vis ? (r_act ? w_pix_bit : w_fill) : 1'b0;
        end
    end

    assign pixel    = r_pixel;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_vga_bw_line_feeder.sv
// Directed bench for vga_bw_line_feeder: drives counters and a host word queue, checks lines and flags.
module tb_vga_bw_line_feeder;

    logic        clk_25mhz = 1'b0;
    logic        reset     = 1'b1;
    logic [9:0]  h_count   = '0;
    logic [9:0]  v_count   = 10'd524;
    logic        s_valid   = 1'b0;
    logic        s_ready;
    logic [15:0] s_data    = '0;
    logic        s_sof     = 1'b0;
    logic        pixel;
    logic        underrun;
    logic        clr_underrun = 1'b0;

    int n_chk = 0;
    int n_bad = 0;
    int n_acc = 0;
    int blank_err = 0;

    logic [15:0]  q_dat [$];
    logic         q_sof [$];
    logic [639:0] line_obs;
    logic [639:0] e_line;

    always #20 clk_25mhz = ~clk_25mhz;

    vga_bw_line_feeder dut (
        .clk_25mhz    (clk_25mhz),
        .reset        (reset),
        .h_count      (h_count),
        .v_count      (v_count),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_sof        (s_sof),
        .pixel        (pixel),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [639:0] rep(input logic [15:0] w);
        logic [639:0] r;
        for (int x = 0; x < 640; x++) r[x] = w[15 - (x % 16)];
        return r;
    endfunction

    function automatic logic [639:0] ur_line(input int v);
        logic [639:0] r;
        for (int x = 0; x < 640; x++) begin
`ifdef VGA_BW_UNDERRUN_PATTERN_EN
            r[x] = 1'(((x >> 5) & 1) ^ ((v >> 5) & 1));
`else
            r[x] = 1'b0;
`endif
        end
        return r;
    endfunction

    task automatic push(input int n, input logic [15:0] w, input logic first_sof);
        for (int i = 0; i < n; i++) begin
            q_dat.push_back(w);
            q_sof.push_back(first_sof && (i == 0));
        end
    endtask

    // One pixel clock: present the queue head, clock, record the pixel for the pre-edge position, advance counters.
    task automatic step();
        logic acc;
        if (q_dat.size() > 0) begin
            s_valid = 1'b1;
            s_data  = q_dat[0];
            s_sof   = q_sof[0];
        end else begin
            s_valid = 1'b0;
            s_data  = '0;
            s_sof   = 1'b0;
        end
        #1;
        acc = s_valid && s_ready;
        @(posedge clk_25mhz);
        #1;
        if (acc) begin
            void'(q_dat.pop_front());
            void'(q_sof.pop_front());
            n_acc++;
        end
        if (h_count < 10'd640) line_obs[h_count] = pixel;
        if (!(h_count < 10'd640 && v_count < 10'd480) && pixel !== 1'b0) blank_err++;
        if (h_count == 10'd799) begin
            h_count = '0;
            v_count = (v_count == 10'd524) ? 10'd0 : v_count + 10'd1;
        end else begin
            h_count = h_count + 10'd1;
        end
    endtask

    task automatic run_until(input int h, input int v);
        int n = 0;
        while (!(h_count == 10'(h) && v_count == 10'(v))) begin
            if (n >= 2000) begin
                n_chk++;
                n_bad++;
                $display("FAIL timeout: pos=%0d,%0d target=%0d,%0d", h_count, v_count, h, v);
                return;
            end
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q_dat.delete();
        q_sof.delete();
        s_valid = 1'b0;
        s_sof   = 1'b0;
        clr_underrun = 1'b0;
        @(posedge clk_25mhz);
        #1;
        reset   = 1'b0;
        h_count = '0;
        v_count = 10'd524;
        n_acc   = 0;
    endtask

    initial begin
        // Basic display, backpressure and the following underrun line
        do_reset();
        chk("rst_pixel", pixel, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready", s_ready, 1);
        push(40, 16'hF0F0, 1'b1);
        push(40, 16'h0000, 1'b1);
        push(40, 16'h8001, 1'b1);
        run_until(100, 524);
        chk("bp_count", n_acc, 80);
        chk("bp_ready_low", s_ready, 0);
        run_until(0, 0);
        line_obs = '0;
        run_until(639, 0);
        chk("bp_hold_count", n_acc, 80);
        chk("bp_ready_hold", s_ready, 0);
        step();
        chk("bp_ready_rise", s_ready, 1);
        run_until(0, 1);
        chk("line0_f0f0", line_obs, rep(16'hF0F0));
        chk("line0_underrun", underrun, 0);
        line_obs = '1;
        run_until(0, 2);
        chk("line1_zero", line_obs, '0);
        line_obs = '0;
        run_until(640, 2);
        chk("line2_underrun", underrun, 0);
        run_until(0, 3);
        chk("line2_8001", line_obs, rep(16'h8001));
        chk("line2_end_underrun", underrun, 1);
        line_obs = '0;
        run_until(0, 4);
        chk("line3_fill", line_obs, ur_line(3));

        // Underrun with no data, set-wins over clear, then recovery
        do_reset();
        h_count = 10'd790;
        run_until(799, 524);
        chk("ur_before_take", underrun, 0);
        step();
        chk("ur_after_take", underrun, 1);
        line_obs = '1;
        run_until(799, 0);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        chk("ur_set_wins", underrun, 1);
        chk("ur_line0_fill", line_obs, ur_line(0));
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        chk("ur_cleared", underrun, 0);
        push(40, 16'hFFFF, 1'b1);
        run_until(0, 2);
        chk("ur_stays_clear", underrun, 0);
        line_obs = '0;
        run_until(0, 3);
        chk("ur_recover_line", line_obs, {640{1'b1}});

        // Race: 40th word on the take edge
        do_reset();
        h_count = 10'd760;
        push(40, 16'hC000, 1'b1);
        run_until(0, 0);
        chk("race_count", n_acc, 40);
        chk("race_underrun", underrun, 1);
        line_obs = '1;
        run_until(0, 1);
        chk("race_line0_fill", line_obs, ur_line(0));
        line_obs = '0;
        run_until(0, 2);
        chk("race_line1_c000", line_obs, rep(16'hC000));

        // Resync mid-line
        do_reset();
        push(10, 16'hFFFF, 1'b1);
        push(1, 16'h8000, 1'b1);
        push(39, 16'h0000, 1'b0);
        run_until(0, 0);
        chk("resync_count", n_acc, 50);
        line_obs = '1;
        run_until(0, 1);
        e_line = '0;
        e_line[0] = 1'b1;
        chk("resync_line", line_obs, e_line);

        // Reset in the middle of a visible line
        do_reset();
        push(40, 16'hFFFF, 1'b1);
        run_until(300, 0);
        chk("mid_pixel_before", pixel, 1);
        #5;
        reset = 1'b1;
        #1;
        chk("mid_pixel_async", pixel, 0);
        @(posedge clk_25mhz);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_ready", s_ready, 1);
        chk("mid_underrun", underrun, 0);

        chk("blank_pixels", blank_err, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
